proc_core_param: RTL

//  Parametrised multicycle processor core. Register file, A and G registers, an ALU and an internal

---
 rtl/proc_pkg.sv | 47 ++++
 rtl/proc_alu.sv | 44 ++++
 rtl/proc_core_param.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | proc_pkg : opcodes, FSM state encoding and ALU operation codes for          |
// |            proc_core_param.                                                 |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package proc_pkg;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4
   } alu_op_t;

   // cmp shares the subtract path; only the writeback differs.
   function automatic alu_op_t alu_op_of(input logic [2:0] opc);
      alu_op_t r;
      case (opc)
         OP_SUB, OP_CMP: r = ALU_SUB;
         OP_AND:         r = ALU_AND;
         OP_OR:          r = ALU_OR;
         OP_XOR:         r = ALU_XOR;
         default:        r = ALU_ADD;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/proc_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | proc_alu : combinational ALU, add/sub with carry-out, and/or/xor (c_out=0). |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module proc_alu
   import proc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          op,
   output logic [WIDTH-1:0] y,
   output logic             c_out
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum   = '0;
      y     = '0;
      c_out = 1'b0;
      case (op)
         ALU_ADD: begin
            sum   = {1'b0, a} + {1'b0, b};
            y     = sum[WIDTH-1:0];
            c_out = sum[WIDTH];
         end
         ALU_SUB: begin
            // c_out=1 means no borrow
            sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            y     = sum[WIDTH-1:0];
            c_out = sum[WIDTH];
         end
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/proc_core_param.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | proc_core_param : parametrised multicycle core (regfile, A, G, ALU, bus mux,|
// |                   control FSM). Macro PROC_FLAGS_EN enables z/c flags + cmp. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module proc_core_param
   import proc_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int NREGS = 8,
   localparam int RW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [WIDTH-1:0] din,
   input  logic [RW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] bus,
   output logic             done,
   output logic             busy,
   output logic             flag_z,
   output logic             flag_c,
   output logic [WIDTH-1:0] dbg_data
);

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] g_q;
   logic [2*RW+2:0]  ir;
   state_t           state;
   state_t           state_n;

   logic [2:0]       op;
   logic [RW-1:0]    rx;
   logic [RW-1:0]    ry;
   logic             is_nop;

   logic [WIDTH-1:0] bus_mux;
   logic [WIDTH-1:0] alu_y;
   logic             alu_c;
   alu_op_t          alu_op;
   logic             done_n;
   logic             wr_rx;
   logic             ld_a;
   logic             ld_g;
   logic             ld_flags;
   logic             ld_ir;

   assign op = ir[2*RW+2:2*RW];
   assign rx = ir[2*RW-1:RW];
   assign ry = ir[RW-1:0];

`ifdef PROC_FLAGS_EN
   assign is_nop = 1'b0;
`else
   assign is_nop = (op == OP_CMP);
`endif

   assign alu_op = alu_op_of(op);

   proc_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a     (a_q),
      .b     (bus_mux),
      .op    (alu_op),
      .y     (alu_y),
      .c_out (alu_c)
   );

   always_comb begin
      state_n  = state;
      bus_mux  = '0;
      done_n   = 1'b0;
      wr_rx    = 1'b0;
      ld_a     = 1'b0;
      ld_g     = 1'b0;
      ld_flags = 1'b0;
      ld_ir    = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               ld_ir   = 1'b1;
               state_n = T1;
            end
         end
         T1: begin
            if (op == OP_MV) begin
               bus_mux = regs[ry];
               wr_rx   = 1'b1;
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (op == OP_MVI) begin
               bus_mux = din;
               wr_rx   = 1'b1;
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (is_nop) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               bus_mux = regs[rx];
               ld_a    = 1'b1;
               state_n = T2;
            end
         end
         T2: begin
            bus_mux  = regs[ry];
            ld_flags = 1'b1;
            if (op == OP_CMP) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               ld_g    = 1'b1;
               state_n = T3;
            end
         end
         T3: begin
            bus_mux = g_q;
            wr_rx   = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ir    <= '0;
         a_q   <= '0;
         g_q   <= '0;
         done  <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         state <= state_n;
         done  <= done_n;
         if (ld_ir) ir <= din[2*RW+2:0];
         if (ld_a)  a_q <= bus_mux;
         if (ld_g)  g_q <= alu_y;
         if (wr_rx) regs[rx] <= bus_mux;
      end
   end

`ifdef PROC_FLAGS_EN
   logic z_q;
   logic c_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         z_q <= 1'b0;
         c_q <= 1'b0;
      end else if (ld_flags) begin
         z_q <= (alu_y == '0);
         c_q <= alu_c;
      end
   end

   assign flag_z = z_q;
   assign flag_c = c_q;
`else
   logic unused_flags;
   assign unused_flags = &{1'b0, alu_c, ld_flags};
   assign flag_z       = 1'b0;
   assign flag_c       = 1'b0;
`endif

   // A reset held in mid-instruction must not leak the old source onto the bus.
   assign bus      = rst ? '0 : bus_mux;
   assign busy     = (state != IDLE);
   assign dbg_data = regs[dbg_sel];

endmodule
`default_nettype wire
